// File: rtl/boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg : state encodings and stream constants for the boot loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package boot_loader_pkg;

  localparam int unsigned HDR_BYTES = 4;

  typedef enum logic [3:0] {
    S_LEN_LO = 4'd0,
    S_LEN_HI = 4'd1,
    S_ADR_LO = 4'd2,
    S_ADR_HI = 4'd3,
    S_DATA   = 4'd4,
    S_SETUP  = 4'd5,
    S_STROBE = 4'd6,
    S_HOLD   = 4'd7,
    S_CKSUM  = 4'd8,
    S_DONE   = 4'd9,
    S_ERROR  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_SETUP  = 2'd1,
    W_STROBE = 2'd2,
    W_HOLD   = 2'd3
  } wr_state_t;

  function automatic logic accepts_input(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_ADR_LO) ||
           (s == S_ADR_HI) || (s == S_DATA)   || (s == S_CKSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_loader_write_strobe.sv
// ---------------------------------------------------------------------------
// boot_loader_write_strobe : SETUP / STROBE x WRITE_CYCLES / HOLD bus sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module boot_loader_write_strobe
  import boot_loader_pkg::*;
#(
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic we_n_o,
  output logic drive_n_o,
  output logic finish_o
);

  wr_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_n_q, we_n_d;
  logic        drive_n_q, drive_n_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= W_IDLE;
      cnt_q     <= 4'd0;
      we_n_q    <= 1'b1;
      drive_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_n_q    <= we_n_d;
      drive_n_q <= drive_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_n_d    = we_n_q;
    drive_n_d = drive_n_q;
    case (state_q)
      W_IDLE: begin
        if (start_i) begin
          state_d   = W_SETUP;
          drive_n_d = 1'b0;
          we_n_d    = 1'b1;
        end
      end
      W_SETUP: begin
        state_d = W_STROBE;
        we_n_d  = 1'b0;
        cnt_d   = 4'(WRITE_CYCLES - 1);
      end
      W_STROBE: begin
        // cnt_q counts the strobe clocks still to go after the current one
        if (cnt_q == 4'd0) begin
          state_d = W_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      W_HOLD: begin
        state_d   = W_IDLE;
        drive_n_d = 1'b1;
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign we_n_o    = we_n_q;
  assign drive_n_o = drive_n_q;
  assign finish_o  = (state_q == W_HOLD);

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader : byte-stream image loader that writes RAM and gates CPU reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          DELAY_RISE   = 0,
  parameter int          DELAY_FALL   = 0,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA,
  output logic        MEM_WE_bar,
  output logic        MEM_DRIVE_bar,
  output logic        CPU_RST_bar,
  output logic        DONE,
  output logic        ERR
);

  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_sim_delay
    // Output delays exist only for timing-annotated simulation; logic is unchanged.
  end

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  sum_q, sum_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        w_accept;
  logic        w_wr_start;
  logic        w_wr_finish;

  assign w_accept = IN_VALID & ready_q;

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q     <= S_LEN_LO;
      ready_q     <= 1'b0;
      addr_q      <= 16'd0;
      data_q      <= 8'd0;
      count_q     <= 16'd0;
      sum_q       <= 8'd0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    count_d     = count_q;
    sum_d       = sum_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    w_wr_start  = 1'b0;
    case (state_q)
      S_LEN_LO: if (w_accept) begin
        count_d[7:0] = IN_DATA;
        state_d      = S_LEN_HI;
      end
      S_LEN_HI: if (w_accept) begin
        count_d[15:8] = IN_DATA;
        state_d       = S_ADR_LO;
      end
      S_ADR_LO: if (w_accept) begin
        addr_d[7:0] = IN_DATA;
        state_d     = S_ADR_HI;
      end
      S_ADR_HI: if (w_accept) begin
        addr_d[15:8] = IN_DATA;
        state_d      = (count_q == 16'd0) ? S_CKSUM : S_DATA;
      end
      S_DATA: if (w_accept) begin
        data_d     = IN_DATA;
        sum_d      = sum_q + IN_DATA;
        w_wr_start = 1'b1;
        state_d    = S_SETUP;
      end
      // The strobe sequencer owns SETUP/STROBE/HOLD; we wait here for its HOLD clock.
      S_SETUP: if (w_wr_finish) begin
        addr_d  = addr_q + 16'd1;
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? S_CKSUM : S_DATA;
      end
      S_CKSUM: if (w_accept) begin
        if (IN_DATA == sum_q) begin
          state_d     = S_DONE;
          cpu_rst_n_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign ready_d = accepts_input(state_d);

  boot_loader_write_strobe #(
    .WRITE_CYCLES (WRITE_CYCLES)
  ) u_write_strobe (
    .clk_i     (CLK),
    .rst_ni    (RST_bar),
    .start_i   (w_wr_start),
    .we_n_o    (MEM_WE_bar),
    .drive_n_o (MEM_DRIVE_bar),
    .finish_o  (w_wr_finish)
  );

  assign IN_READY    = ready_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_DATA    = data_q;
  assign CPU_RST_bar = cpu_rst_n_q;
  assign DONE        = done_q;
  assign ERR         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader : directed streams with a write scoreboard for boot_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int unsigned WC = 3;

  logic        CLK = 1'b0;
  logic        RST_bar = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_WE_bar;
  logic        MEM_DRIVE_bar;
  logic        CPU_RST_bar;
  logic        DONE;
  logic        ERR;

  boot_loader #(
    .DELAY_RISE   (0),
    .DELAY_FALL   (0),
    .WRITE_CYCLES (WC)
  ) dut (
    .CLK           (CLK),
    .RST_bar       (RST_bar),
    .IN_DATA       (IN_DATA),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_DATA      (MEM_DATA),
    .MEM_WE_bar    (MEM_WE_bar),
    .MEM_DRIVE_bar (MEM_DRIVE_bar),
    .CPU_RST_bar   (CPU_RST_bar),
    .DONE          (DONE),
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  gaps  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // Monitor: every write pulse pops one expected write; pulse width and bus stability checked.
  bit        in_pulse = 1'b0;
  int        width = 0;
  logic [23:0] cur_bus = 24'h0;
  wr_t       e;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_bar) begin
        in_pulse = 1'b0;
        width    = 0;
      end else if (MEM_WE_bar === 1'b0) begin
        check("drive_low_during_we", {31'd0, MEM_DRIVE_bar}, 32'd0);
        if (!in_pulse) begin
          in_pulse = 1'b1;
          width    = 0;
          cur_bus  = {MEM_ADDR, MEM_DATA};
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write", MEM_ADDR, MEM_DATA);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {16'd0, MEM_ADDR}, {16'd0, e.a});
            check("wr_data", {24'd0, MEM_DATA}, {24'd0, e.d});
          end
        end else begin
          check("bus_stable_during_we", {8'd0, MEM_ADDR, MEM_DATA}, {8'd0, cur_bus});
        end
        width++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("we_width", width, WC);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b);
    int t;
    if (gaps) repeat ($urandom_range(0, 4)) @(negedge CLK);
    IN_DATA  = b;
    IN_VALID = 1'b1;
    t = 0;
    while (IN_READY !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got IN_READY=%b after %0d clocks, expected 1", IN_READY, t);
      IN_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    for (int i = 0; i < s.size(); i++) begin
      send(s[i]);
      if (i == HDR_BYTES - 1)
        check("start_addr", {16'd0, MEM_ADDR}, {16'd0, s[3], s[2]});
    end
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    RST_bar  = 1'b0;
    repeat (2) @(negedge CLK);
    RST_bar  = 1'b1;
    @(negedge CLK);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, {31'd0, DONE}, 32'd1);
    check({tag, "_err"}, {31'd0, ERR}, 32'd0);
    check({tag, "_cpu_rst"}, {31'd0, CPU_RST_bar}, 32'd1);
    check({tag, "_ready"}, {31'd0, IN_READY}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  logic [7:0] s[$];
  int         t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_ready", {31'd0, IN_READY}, 32'd0);
    check("rst_addr", {16'd0, MEM_ADDR}, 32'd0);
    check("rst_data", {24'd0, MEM_DATA}, 32'd0);
    check("rst_we", {31'd0, MEM_WE_bar}, 32'd1);
    check("rst_drive", {31'd0, MEM_DRIVE_bar}, 32'd1);
    check("rst_cpu", {31'd0, CPU_RST_bar}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    RST_bar = 1'b1;
    check("ready_before_edge", {31'd0, IN_READY}, 32'd0);
    @(negedge CLK);
    check("ready_after_edge", {31'd0, IN_READY}, 32'd1);

    // Three-byte image at 0x8000, valid held high
    push_wr(16'h8000, 8'h11);
    push_wr(16'h8001, 8'h22);
    push_wr(16'h8002, 8'h33);
    s = '{8'h03, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33};
    send_stream(s);
    check("t1_cpu_before_cksum", {31'd0, CPU_RST_bar}, 32'd0);
    send(8'h66);
    check_done("t1");

    // Zero-length image
    do_reset();
    s = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h00};
    send_stream(s);
    check_done("t2");

    // Bad checksum
    do_reset();
    push_wr(16'h1000, 8'hAA);
    push_wr(16'h1001, 8'h55);
    s = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'h55, 8'h00};
    send_stream(s);
    check("t3_err", {31'd0, ERR}, 32'd1);
    check("t3_done", {31'd0, DONE}, 32'd0);
    check("t3_cpu_rst", {31'd0, CPU_RST_bar}, 32'd0);
    IN_VALID = 1'b1;
    repeat (5) @(negedge CLK);
    IN_VALID = 1'b0;
    check("t3_ready_stays_low", {31'd0, IN_READY}, 32'd0);
    check("t3_err_sticky", {31'd0, ERR}, 32'd1);
    check("t3_pending", exp_q.size(), 32'd0);

    // Address wrap
    do_reset();
    push_wr(16'hFFFF, 8'h01);
    push_wr(16'h0000, 8'h02);
    s = '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03};
    send_stream(s);
    check_done("t4");

    // Reset during the second byte's strobe
    do_reset();
    push_wr(16'h3000, 8'hA1);
    push_wr(16'h3001, 8'hB2);
    s = '{8'h02, 8'h00, 8'h00, 8'h30, 8'hA1, 8'hB2};
    send_stream(s);
    t = 0;
    while (MEM_WE_bar !== 1'b0 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    check("t5_strobe_seen", {31'd0, MEM_WE_bar}, 32'd0);
    @(posedge CLK);
    #2;
    RST_bar = 1'b0;
    #1;
    check("t5_we_async", {31'd0, MEM_WE_bar}, 32'd1);
    check("t5_cpu_async", {31'd0, CPU_RST_bar}, 32'd0);
    check("t5_ready_async", {31'd0, IN_READY}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_bar = 1'b1;
    @(negedge CLK);
    check("t5_pending", exp_q.size(), 32'd0);
    push_wr(16'h2000, 8'h5A);
    s = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h5A, 8'h5A};
    send_stream(s);
    check_done("t5");

    // Random valid gaps, same image as the first stream
    do_reset();
    gaps = 1'b1;
    push_wr(16'h8000, 8'h11);
    push_wr(16'h8001, 8'h22);
    push_wr(16'h8002, 8'h33);
    s = '{8'h03, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h66};
    send_stream(s);
    check_done("t6");
    gaps = 1'b0;

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
